// File: rtl/n3l_filter_pipe_if.sv
// Pair-stream bundle for the Newton's-third-law filter: input pair handshake plus kept-pair output.
// master = producer/consumer side, slave = filter side.
interface n3l_filter_pipe_if #(
   parameter int COORD_W = 32,
   parameter int DIMS    = 3,
   parameter int TAG_W   = 16
) ();
   logic                    mode_half;
   logic                    in_valid;
   logic                    in_ready;
   logic [DIMS*COORD_W-1:0] in_ref;
   logic [DIMS*COORD_W-1:0] in_nbr;
   logic [TAG_W-1:0]        in_tag;
   logic                    out_valid;
   logic                    out_ready;
   logic [DIMS*COORD_W-1:0] out_off;
   logic [TAG_W-1:0]        out_tag;

   modport master (
      output mode_half, in_valid, in_ref, in_nbr, in_tag, out_ready,
      input  in_ready, out_valid, out_off, out_tag
   );

   modport slave (
      input  mode_half, in_valid, in_ref, in_nbr, in_tag, out_ready,
      output in_ready, out_valid, out_off, out_tag
   );
endinterface

// File: rtl/n3l_filter_pipe.sv
// Streaming N3L pair filter: wraps periodic cell offsets, keeps half- or full-shell pairs,
// two-stage valid/ready pipeline with saturating pass/drop counters.
module n3l_filter_pipe #(
   parameter int COORD_W   = 32,
   parameter int DIMS      = 3,
   parameter int CELLS     = 8,
   parameter int TAG_W     = 16,
   parameter int KEEP_SELF = 0,
   parameter int CNT_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   n3l_filter_pipe_if.slave      bus,
   input  logic                  count_clr,
   output logic [CNT_W-1:0]      pass_cnt,
   output logic [CNT_W-1:0]      drop_cnt
);

   localparam logic signed [COORD_W:0] CELLS_S = (COORD_W+1)'(CELLS);
   localparam logic signed [COORD_W:0] H_S     = (COORD_W+1)'(CELLS / 2);

   // Offsets exactly +-H keep their raw sign so (a,b) and (b,a) always mirror each other.
   function automatic logic [COORD_W-1:0] wrap_off(input logic [COORD_W-1:0] r,
                                                   input logic [COORD_W-1:0] n);
      logic signed [COORD_W:0] d;
      d = $signed({1'b0, n}) - $signed({1'b0, r});
      if (d > H_S)
         d = d - CELLS_S;
      else if (d < -H_S)
         d = d + CELLS_S;
      return d[COORD_W-1:0];
   endfunction

   function automatic logic keep_fn(input logic [DIMS*COORD_W-1:0] off, input logic half);
      logic self_p;
      logic pos;
      self_p = 1'b1;
      pos    = 1'b0;
      for (int d = DIMS - 1; d >= 0; d--) begin
         if (off[d*COORD_W +: COORD_W] != '0) begin
            self_p = 1'b0;
            pos    = ~off[d*COORD_W + COORD_W - 1];
         end
      end
      if (self_p)
         return (KEEP_SELF != 0);
      else if (half)
         return pos;
      else
         return 1'b1;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   logic                    vld_p1, vld_p2;
   logic                    mode_p1, mode_p2;
   logic [DIMS*COORD_W-1:0] off_p1, off_p2;
   logic [TAG_W-1:0]        tag_p1, tag_p2;
   logic [DIMS*COORD_W-1:0] off_in;
   logic                    keep_p2, adv_p1, adv_p2, load_p1, load_p2, accept;

   always_comb begin
      off_in = '0;
      for (int d = 0; d < DIMS; d++)
         off_in[d*COORD_W +: COORD_W] = wrap_off(bus.in_ref[d*COORD_W +: COORD_W],
                                                 bus.in_nbr[d*COORD_W +: COORD_W]);
   end

   assign keep_p2      = keep_fn(off_p2, mode_p2);
   assign adv_p2       = vld_p2 & (~keep_p2 | bus.out_ready);
   assign load_p2      = ~vld_p2 | adv_p2;
   assign adv_p1       = vld_p1 & load_p2;
   assign load_p1      = ~vld_p1 | adv_p1;
   assign bus.in_ready = rst_n & load_p1;
   assign accept       = bus.in_valid & bus.in_ready;

   assign bus.out_valid = vld_p2 & keep_p2;
   assign bus.out_off   = off_p2;
   assign bus.out_tag   = tag_p2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         mode_p1 <= 1'b0;
         off_p1  <= '0;
         tag_p1  <= '0;
         vld_p2  <= 1'b0;
         mode_p2 <= 1'b0;
         off_p2  <= '0;
         tag_p2  <= '0;
      end else begin
         // stage 1: wrapped offsets of the accepted pair
         if (load_p1) begin
            vld_p1 <= accept;
            if (accept) begin
               off_p1  <= off_in;
               tag_p1  <= bus.in_tag;
               mode_p1 <= bus.mode_half;
            end
         end
         // stage 2: keep/drop decision drives the output
         if (load_p2) begin
            vld_p2  <= vld_p1;
            off_p2  <= off_p1;
            tag_p2  <= tag_p1;
            mode_p2 <= mode_p1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || count_clr) begin
         pass_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         if (bus.out_valid && bus.out_ready)
            pass_cnt <= sat_inc(pass_cnt);
         if (vld_p2 && !keep_p2)
            drop_cnt <= sat_inc(drop_cnt);
      end
   end

endmodule

// File: tb/tb_n3l_filter_pipe.sv
// Bench for n3l_filter_pipe: directed pair vectors, queue-based reference model, literal spot checks.
module tb_n3l_filter_pipe;
   localparam int CW    = 32;
   localparam int DM    = 3;
   localparam int CELLS = 8;
   localparam int TW    = 16;
   localparam int CNT_W = 4;

   logic            clk;
   logic            rst_n;
   logic            count_clr;
   logic            count_clr_k;
   logic [CNT_W-1:0] pass_cnt, drop_cnt;
   logic [7:0]      pass_k, drop_k;

   int errors = 0;
   int checks = 0;

   n3l_filter_pipe_if #(.COORD_W(CW), .DIMS(DM), .TAG_W(TW)) bus ();
   n3l_filter_pipe_if #(.COORD_W(CW), .DIMS(DM), .TAG_W(TW)) bus_k ();

   n3l_filter_pipe #(.COORD_W(CW), .DIMS(DM), .CELLS(CELLS), .TAG_W(TW), .KEEP_SELF(0), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave), .count_clr(count_clr),
      .pass_cnt(pass_cnt), .drop_cnt(drop_cnt));

   n3l_filter_pipe #(.COORD_W(CW), .DIMS(DM), .CELLS(CELLS), .TAG_W(TW), .KEEP_SELF(1), .CNT_W(8)) dut_k (
      .clk(clk), .rst_n(rst_n), .bus(bus_k.slave), .count_clr(count_clr_k),
      .pass_cnt(pass_k), .drop_cnt(drop_k));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DM*CW-1:0] pk(input int a, input int b, input int c);
      return {c[31:0], b[31:0], a[31:0]};
   endfunction

   // Reference: plain integer difference with one periodic fold toward zero.
   function automatic logic [DM*CW-1:0] m_off(input logic [DM*CW-1:0] r, input logic [DM*CW-1:0] n);
      logic [DM*CW-1:0] o;
      longint dr;
      o = '0;
      for (int d = 0; d < DM; d++) begin
         dr = longint'(n[d*CW +: CW]) - longint'(r[d*CW +: CW]);
         if (dr > CELLS / 2)
            dr = dr - CELLS;
         else if (dr < -(CELLS / 2))
            dr = dr + CELLS;
         o[d*CW +: CW] = dr[31:0];
      end
      return o;
   endfunction

   function automatic bit m_keep(input logic [DM*CW-1:0] off, input bit half);
      int v;
      for (int d = 0; d < DM; d++) begin
         v = int'($signed(off[d*CW +: CW]));
         if (v != 0)
            return half ? (v > 0) : 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic int sat(input int v);
      return (v >= (1 << CNT_W) - 1) ? v : v + 1;
   endfunction

   typedef struct packed {
      logic [DM*CW-1:0] off;
      logic [TW-1:0]    tag;
   } exp_t;

   exp_t q[$];
   int   m_pass = 0;
   int   m_drop = 0;

   always @(negedge clk) begin
      logic [DM*CW-1:0] o;
      if (!rst_n) begin
         q.delete();
         m_pass = 0;
         m_drop = 0;
      end else begin
         if (bus.out_valid) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got out_valid with tag %0h, expected no output", bus.out_tag);
            end else begin
               check("sb_off", bus.out_off, q[0].off);
               check("sb_tag", bus.out_tag, q[0].tag);
               if (bus.out_ready) begin
                  void'(q.pop_front());
                  m_pass = sat(m_pass);
               end
            end
         end
         if (count_clr) begin
            m_pass = 0;
            m_drop = 0;
         end
         if (bus.in_valid && bus.in_ready) begin
            o = m_off(bus.in_ref, bus.in_nbr);
            if (m_keep(o, bus.mode_half))
               q.push_back('{off: o, tag: bus.in_tag});
            else
               m_drop = sat(m_drop);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int r0, input int r1, input int r2,
                       input int n0, input int n1, input int n2,
                       input int tag, input bit half);
      int t;
      bus.in_ref    = pk(r0, r1, r2);
      bus.in_nbr    = pk(n0, n1, n2);
      bus.in_tag    = tag[15:0];
      bus.mode_half = half;
      bus.in_valid  = 1'b1;
      t = 0;
      @(negedge clk);
      while (!bus.in_ready && t < 50) begin
         t++;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready got 0, expected 1");
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain_check(input string name, input int exp_pass, input int exp_drop);
      tick(4);
      check({name, "_pass"}, pass_cnt, exp_pass);
      check({name, "_drop"}, drop_cnt, exp_drop);
      check({name, "_mpass"}, pass_cnt, m_pass);
      check({name, "_mdrop"}, drop_cnt, m_drop);
      check({name, "_empty"}, q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exceeded, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DM*CW-1:0] nb5[4];
      int acc;
      int t;
      nb5[0] = pk(1, 0, 0);
      nb5[1] = pk(2, 0, 0);
      nb5[2] = pk(0, 1, 0);
      nb5[3] = pk(0, 0, 3);

      rst_n = 1'b0;
      count_clr = 1'b0;
      count_clr_k = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.mode_half = 1'b1;
      bus.in_ref = '0; bus.in_nbr = '0; bus.in_tag = '0;
      bus_k.in_valid = 1'b0; bus_k.out_ready = 1'b1; bus_k.mode_half = 1'b1;
      bus_k.in_ref = '0; bus_k.in_nbr = '0; bus_k.in_tag = '0;

      // model pins against hand-worked offsets and decisions
      check("pin_wrap_7_0", m_off(pk(7, 0, 0), pk(0, 0, 0)), pk(1, 0, 0));
      check("pin_wrap_0_7", m_off(pk(0, 0, 0), pk(7, 0, 0)), pk(-1, 0, 0));
      check("pin_tie", m_off(pk(0, 2, 0), pk(4, 2, 0)), pk(4, 0, 0));
      check("pin_tie_swap", m_off(pk(4, 2, 0), pk(0, 2, 0)), 96'h0_00000000_FFFFFFFC);
      check("pin_keep_negz", m_keep(pk(0, 0, -1), 1'b1), 0);
      check("pin_keep_full", m_keep(pk(0, -1, 0), 1'b0), 1);

      tick(3);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_pass", pass_cnt, 0);
      check("rst_drop", drop_cnt, 0);
      check("rst_off", bus.out_off, 0);
      check("rst_tag", bus.out_tag, 0);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", bus.in_ready, 1);

      // 1: basic half-shell keep with latency
      send(0, 0, 0, 1, 0, 0, 'h11, 1'b1);
      check("t1_not_early", bus.out_valid, 0);
      tick(1);
      check("t1_valid", bus.out_valid, 1);
      check("t1_off", bus.out_off, pk(1, 0, 0));
      check("t1_tag", bus.out_tag, 'h11);
      tick(1);
      check("t1_pass", pass_cnt, 1);

      // 2: periodic wrap both orders
      send(7, 0, 0, 0, 0, 0, 'h22, 1'b1);
      send(0, 0, 0, 7, 0, 0, 'h23, 1'b1);
      drain_check("t2", 2, 1);

      // 3: tie at |r|==H and lower-priority negative axis
      send(0, 2, 0, 4, 2, 0, 'h31, 1'b1);
      send(4, 2, 0, 0, 2, 0, 'h32, 1'b1);
      send(1, 1, 1, 1, 1, 0, 'h33, 1'b1);
      drain_check("t3", 3, 3);

      // 4: self pair in both modes, full-shell keep of a negative offset
      send(3, 3, 3, 3, 3, 3, 'h41, 1'b1);
      send(3, 3, 3, 3, 3, 3, 'h42, 1'b0);
      send(0, 0, 0, 0, 7, 0, 'h43, 1'b0);
      tick(1);
      check("t4_valid", bus.out_valid, 1);
      check("t4_off", bus.out_off, 96'h0_FFFFFFFF_00000000);
      check("t4_tag", bus.out_tag, 'h43);
      drain_check("t4", 4, 5);

      // 4b: KEEP_SELF=1 instance keeps the self pair
      check("k_in_ready", bus_k.in_ready, 1);
      bus_k.in_ref = pk(3, 3, 3);
      bus_k.in_nbr = pk(3, 3, 3);
      bus_k.in_tag = 16'h4A;
      bus_k.in_valid = 1'b1;
      tick(1);
      bus_k.in_valid = 1'b0;
      tick(1);
      check("k_valid", bus_k.out_valid, 1);
      check("k_off", bus_k.out_off, 0);
      check("k_tag", bus_k.out_tag, 'h4A);
      tick(1);
      check("k_pass", pass_k, 1);
      check("k_drop", drop_k, 0);

      // 5: backpressure
      count_clr = 1'b1;
      tick(1);
      count_clr = 1'b0;
      check("t5_clr_pass", pass_cnt, 0);
      check("t5_clr_drop", drop_cnt, 0);
      bus.out_ready = 1'b0;
      bus.mode_half = 1'b1;
      bus.in_ref = pk(0, 0, 0);
      acc = 0;
      for (int c = 0; c < 5; c++) begin
         bus.in_valid = 1'b1;
         bus.in_nbr = nb5[acc];
         bus.in_tag = 16'(16'h51 + acc);
         @(negedge clk);
         if (bus.in_ready) acc++;
         @(posedge clk);
         #1;
      end
      check("t5_accepted", acc, 2);
      check("t5_in_ready_low", bus.in_ready, 0);
      check("t5_hold_valid", bus.out_valid, 1);
      check("t5_hold_tag", bus.out_tag, 'h51);
      bus.out_ready = 1'b1;
      t = 0;
      while (acc < 4 && t < 20) begin
         bus.in_valid = 1'b1;
         bus.in_nbr = nb5[acc];
         bus.in_tag = 16'(16'h51 + acc);
         @(negedge clk);
         if (bus.in_ready) acc++;
         @(posedge clk);
         #1;
         t++;
      end
      bus.in_valid = 1'b0;
      check("t5_all_accepted", acc, 4);
      drain_check("t5", 4, 0);

      // 6: drop saturation, clear-wins, reset with pairs in flight
      count_clr = 1'b1;
      tick(1);
      count_clr = 1'b0;
      for (int i = 0; i < 20; i++)
         send(0, 0, 0, 7, 0, 0, 'h600 + i, 1'b1);
      drain_check("t6_sat", 0, 15);
      count_clr = 1'b1;
      tick(1);
      count_clr = 1'b0;
      check("t6_clr_drop", drop_cnt, 0);
      send(0, 0, 0, 7, 0, 0, 'h66, 1'b1);
      tick(1);
      count_clr = 1'b1;
      tick(1);
      count_clr = 1'b0;
      check("t6_clr_wins", drop_cnt, 0);
      send(0, 0, 0, 7, 0, 0, 'h67, 1'b1);
      send(0, 0, 0, 1, 0, 0, 'h68, 1'b1);
      drain_check("t6_pre", 1, 1);
      bus.out_ready = 1'b0;
      send(0, 0, 0, 1, 0, 0, 'h71, 1'b1);
      send(0, 0, 0, 0, 1, 0, 'h72, 1'b1);
      check("t6_stalled_valid", bus.out_valid, 1);
      rst_n = 1'b0;
      tick(1);
      check("t6_rst_valid", bus.out_valid, 0);
      check("t6_rst_pass", pass_cnt, 0);
      check("t6_rst_drop", drop_cnt, 0);
      check("t6_rst_in_ready", bus.in_ready, 0);
      check("t6_rst_tag", bus.out_tag, 0);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      tick(4);
      check("t6_post_valid", bus.out_valid, 0);
      check("t6_post_pass", pass_cnt, 0);
      check("end_queue_empty", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
